// File: rtl/fourier_srg.sv
// Ten-point DFT engine: samples are loaded into a register file, one complex
// multiply-accumulate runs per clock, and the rounded bins are read back by index.
module fourier_srg #(
  parameter int n = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] x,
  input  logic [1:0]  operation,
  output logic [31:0] y_re,
  output logic [31:0] y_im,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_PROC = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [3:0] LAST    = 4'(n - 1);

  state_t             r_state;
  logic [3:0]         r_k;
  logic [3:0]         r_j;
  logic signed [63:0] r_acc_re;
  logic signed [63:0] r_acc_im;
  logic               r_done;
  logic [31:0]        r_mem    [n];
  logic [31:0]        r_res_re [n];
  logic [31:0]        r_res_im [n];

  logic               w_addr_ok;
  logic [7:0]         w_jk;
  logic [3:0]         w_m;
  logic signed [15:0] w_cos;
  logic signed [15:0] w_sin;
  logic signed [31:0] w_x;
  logic signed [47:0] w_prod_re;
  logic signed [47:0] w_prod_im;
  logic signed [63:0] w_acc_re_next;
  logic signed [63:0] w_acc_im_next;

  assign w_addr_ok = (addr < 32'(n));

  // Twiddle index is j*k folded into one period of the Q1.14 ROM.
  assign w_jk = 8'(r_j) * 8'(r_k);
  assign w_m  = 4'(w_jk % 8'(n));

  always_comb begin
    w_cos = 16'sd0;
    w_sin = 16'sd0;
    case (w_m)
      4'd0: begin w_cos =  16'sd16384; w_sin =  16'sd0;     end
      4'd1: begin w_cos =  16'sd13255; w_sin =  16'sd9630;  end
      4'd2: begin w_cos =  16'sd5063;  w_sin =  16'sd15582; end
      4'd3: begin w_cos = -16'sd5063;  w_sin =  16'sd15582; end
      4'd4: begin w_cos = -16'sd13255; w_sin =  16'sd9630;  end
      4'd5: begin w_cos = -16'sd16384; w_sin =  16'sd0;     end
      4'd6: begin w_cos = -16'sd13255; w_sin = -16'sd9630;  end
      4'd7: begin w_cos = -16'sd5063;  w_sin = -16'sd15582; end
      4'd8: begin w_cos =  16'sd5063;  w_sin = -16'sd15582; end
      4'd9: begin w_cos =  16'sd13255; w_sin = -16'sd9630;  end
      default: begin w_cos = 16'sd0;   w_sin = 16'sd0;      end
    endcase
  end

  assign w_x       = $signed(r_mem[r_j]);
  assign w_prod_re = 48'(w_x) * 48'(w_cos);
  assign w_prod_im = 48'(w_x) * 48'(w_sin);

  // The imaginary part uses the negative-exponent kernel, so sine products subtract.
  assign w_acc_re_next = r_acc_re + 64'(w_prod_re);
  assign w_acc_im_next = r_acc_im - 64'(w_prod_im);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < n; i++) begin
        r_mem[i] <= '0;
      end
    end else if (operation == OP_LOAD && w_addr_ok) begin
      r_mem[addr[3:0]] <= x;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_k      <= '0;
      r_j      <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      for (int i = 0; i < n; i++) begin
        r_res_re[i] <= '0;
        r_res_im[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (operation == OP_PROC) begin
            r_state  <= S_PROC;
            r_k      <= '0;
            r_j      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
          end
        end
        S_PROC: begin
          if (operation != OP_PROC) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_k      <= '0;
            r_j      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
          end else if (r_j == LAST) begin
            // Round half up in Q1.14, then keep only the low 32 bits.
            r_res_re[r_k] <= 32'((w_acc_re_next + 64'sd8192) >>> 14);
            r_res_im[r_k] <= 32'((w_acc_im_next + 64'sd8192) >>> 14);
            r_acc_re      <= '0;
            r_acc_im      <= '0;
            r_j           <= '0;
            if (r_k == LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_k     <= '0;
            end else begin
              r_k <= r_k + 4'd1;
            end
          end else begin
            r_acc_re <= w_acc_re_next;
            r_acc_im <= w_acc_im_next;
            r_j      <= r_j + 4'd1;
          end
        end
        S_DONE: begin
          if (operation == OP_IDLE || operation == OP_LOAD) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Readback is purely combinational and deliberately ignores done.
  assign y_re = (operation == OP_READ && w_addr_ok) ? r_res_re[addr[3:0]] : '0;
  assign y_im = (operation == OP_READ && w_addr_ok) ? r_res_im[addr[3:0]] : '0;
  assign done = r_done;

endmodule

// File: tb/tb_fourier_srg.sv
// Directed bench for fourier_srg: ramp, impulse, constant and negative-impulse
// transforms, plus abort, mid-run reset and out-of-range readback.
module tb_fourier_srg;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] x;
  logic [1:0]  operation;
  logic [31:0] y_re;
  logic [31:0] y_im;
  logic        done;

  int total;
  int bad;
  logic [31:0] vecX [10];

  fourier_srg #(.n(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .x         (x),
    .operation (operation),
    .y_re      (y_re),
    .y_im      (y_im),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadVec();
    for (int i = 0; i < 10; i++) begin
      operation = 2'b01;
      addr      = 32'(i);
      x         = vecX[i];
      tick();
    end
    operation = 2'b00;
    addr      = '0;
    x         = '0;
  endtask

  // Returns the edge number (sampling edge = 1) on which done was first seen, 0 on timeout.
  task automatic runDft(output int edges);
    edges     = 0;
    operation = 2'b10;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (done === 1'b1) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic readRes(input int a, output logic [31:0] re, output logic [31:0] im);
    operation = 2'b11;
    addr      = 32'(a);
    #1;
    re = y_re;
    im = y_im;
  endtask

  task automatic finishRun();
    operation = 2'b00;
    addr      = '0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    operation = 2'b11;
    addr      = '0;
    x         = 32'h1234_5678;
    #12;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    total++;
    if (y_re !== 32'd0 || y_im !== 32'd0) begin
      bad++;
      $display("FAIL reset_out got=(%0d,%0d) want=(0,0)", $signed(y_re), $signed(y_im));
    end
    @(posedge clk);
    #1;
    reset     = 1'b1;
    operation = 2'b00;
    tick();
  endtask

  task automatic test_ramp();
    int edges;
    logic [31:0] re, im;
    int addrs [4] = '{0, 1, 5, 9};
    int expRe [4] = '{45, -5, -5, -5};
    int expIm [4] = '{0, 15, 0, -15};
    for (int i = 0; i < 10; i++) vecX[i] = 32'(i);
    loadVec();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL ramp_load_done got=%b want=0", done);
    end
    runDft(edges);
    total++;
    if (edges !== 101) begin
      bad++;
      $display("FAIL ramp_latency got=%0d want=101", edges);
    end
    for (int i = 0; i < 4; i++) begin
      readRes(addrs[i], re, im);
      total++;
      if (re !== expRe[i] || im !== expIm[i]) begin
        bad++;
        $display("FAIL ramp_bin%0d got=(%0d,%0d) want=(%0d,%0d)",
                 addrs[i], $signed(re), $signed(im), expRe[i], expIm[i]);
      end
    end
    finishRun();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_clear got=%b want=0", done);
    end
  endtask

  task automatic test_impulse();
    int edges;
    logic [31:0] re, im;
    for (int i = 0; i < 10; i++) vecX[i] = '0;
    vecX[0] = 32'd100;
    loadVec();
    // addr 16 aliases slot 0 in its low bits; the write must be dropped
    operation = 2'b01;
    addr      = 32'd16;
    x         = 32'd999;
    tick();
    operation = 2'b00;
    runDft(edges);
    total++;
    if (edges !== 101) begin
      bad++;
      $display("FAIL impulse_latency got=%0d want=101", edges);
    end
    for (int k = 0; k < 10; k++) begin
      readRes(k, re, im);
      total++;
      if (re !== 32'd100 || im !== 32'd0) begin
        bad++;
        $display("FAIL impulse_bin%0d got=(%0d,%0d) want=(100,0)", k, $signed(re), $signed(im));
      end
    end
    finishRun();
  endtask

  task automatic test_constant();
    int edges;
    int wantRe;
    logic [31:0] re, im;
    for (int i = 0; i < 10; i++) vecX[i] = 32'd7;
    loadVec();
    runDft(edges);
    for (int k = 0; k < 10; k++) begin
      wantRe = (k == 0) ? 70 : 0;
      readRes(k, re, im);
      total++;
      if (re !== wantRe || im !== 32'd0) begin
        bad++;
        $display("FAIL const_bin%0d got=(%0d,%0d) want=(%0d,0)", k, $signed(re), $signed(im), wantRe);
      end
    end
    finishRun();
  endtask

  task automatic test_neg_impulse();
    int edges;
    logic [31:0] re, im;
    for (int i = 0; i < 10; i++) vecX[i] = '0;
    vecX[0] = 32'hFFFF_FC18;
    loadVec();
    runDft(edges);
    for (int k = 0; k < 10; k++) begin
      readRes(k, re, im);
      total++;
      if (re !== 32'hFFFF_FC18 || im !== 32'd0) begin
        bad++;
        $display("FAIL negimp_bin%0d got=(%h,%h) want=(fffffc18,00000000)", k, re, im);
      end
    end
    finishRun();
  endtask

  task automatic test_abort();
    int edges;
    logic sawDone;
    logic [31:0] re, im;
    for (int i = 0; i < 10; i++) vecX[i] = 32'(i);
    loadVec();
    sawDone   = 1'b0;
    operation = 2'b10;
    for (int e = 1; e < 50; e++) begin
      tick();
      if (done !== 1'b0) sawDone = 1'b1;
    end
    operation = 2'b00;
    for (int e = 0; e < 70; e++) begin
      tick();
      if (done !== 1'b0) sawDone = 1'b1;
    end
    total++;
    if (sawDone !== 1'b0) begin
      bad++;
      $display("FAIL abort_done got=1 want=0");
    end
    runDft(edges);
    total++;
    if (edges !== 101) begin
      bad++;
      $display("FAIL abort_rerun_latency got=%0d want=101", edges);
    end
    readRes(1, re, im);
    total++;
    if (re !== -5 || im !== 15) begin
      bad++;
      $display("FAIL abort_rerun_bin1 got=(%0d,%0d) want=(-5,15)", $signed(re), $signed(im));
    end
    readRes(10, re, im);
    total++;
    if (re !== 32'd0 || im !== 32'd0) begin
      bad++;
      $display("FAIL out_of_range got=(%0d,%0d) want=(0,0)", $signed(re), $signed(im));
    end
    finishRun();
  endtask

  task automatic test_reset_mid_run();
    int edges;
    logic [31:0] re, im;
    operation = 2'b10;
    repeat (30) tick();
    reset = 1'b0;
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_done got=%b want=0", done);
    end
    readRes(1, re, im);
    total++;
    if (re !== 32'd0 || im !== 32'd0) begin
      bad++;
      $display("FAIL midreset_out got=(%0d,%0d) want=(0,0)", $signed(re), $signed(im));
    end
    readRes(0, re, im);
    total++;
    if (re !== 32'd0) begin
      bad++;
      $display("FAIL midreset_bin0 got=%0d want=0", $signed(re));
    end
    operation = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    // samples were cleared too, so a fresh run must produce all-zero bins
    runDft(edges);
    total++;
    if (edges !== 101) begin
      bad++;
      $display("FAIL postreset_latency got=%0d want=101", edges);
    end
    readRes(0, re, im);
    total++;
    if (re !== 32'd0 || im !== 32'd0) begin
      bad++;
      $display("FAIL postreset_bin0 got=(%0d,%0d) want=(0,0)", $signed(re), $signed(im));
    end
    finishRun();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    operation = 2'b00;
    addr      = '0;
    x         = '0;
    test_reset();
    test_ramp();
    test_impulse();
    test_constant();
    test_neg_impulse();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourier_srg.md
FOURIER_SRG -- requirements
Module: fourier_srg

Interface
REQ-001 SHALL have parameter n, default 10, number of DFT points; only n=10 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  32  sample index for load (operation 01) and result index for read (operation 11).
REQ-005 SHALL have port x  input  32  signed input sample, written at addr during load.
REQ-006 SHALL have port operation  input  2  command: 00 idle, 01 load, 10 process, 11 read.
REQ-007 SHALL have port y_re  output  32  signed real part of result[addr].
REQ-008 SHALL have port y_im  output  32  signed imaginary part of result[addr].
REQ-009 SHALL have port done  output  1  high when a complete DFT result set is valid.

Function
REQ-010 SHALL compute y[k] = sum over j=0..n-1 of x[j]·W(j·k mod n), with real part +Σ x·cos(2π·m/n) and imaginary part −Σ x·sin(2π·m/n).
REQ-011 SHALL use a signed Q1.14 twiddle ROM indexed by m=0..9, with cos = 16384, 13255, 5063, −5063, −13255, −16384, −13255, −5063, 5063, 13255.
REQ-012 SHALL use sin = 0, 9630, 15582, 15582, 9630, 0, −9630, −15582, −15582, −9630 in the same ROM.
REQ-013 SHALL accumulate in 64-bit signed registers, one re and one im product per cycle, using two 32x16 signed multipliers.
REQ-014 SHALL form each output as (acc + 8192) >>> 14 (arithmetic shift), truncated to the low 32 bits; wrap on overflow.
REQ-015 SHALL store samples in an n x 32 register array; on a rising edge with operation=01, mem[addr] <= x.
REQ-016 SHALL ignore load writes when addr >= n.
REQ-017 SHALL run a state machine IDLE -> PROC -> DONE.
REQ-018 IDLE: on an edge with operation=10, SHALL clear k, j and the accumulators and enter PROC; done stays 0.
REQ-019 PROC: each edge SHALL accumulate the product for (k, j) and increment j.
REQ-020 PROC: when j=n-1, SHALL write the rounded result to result[k], clear the accumulators, set j=0 and increment k.
REQ-021 PROC: after k=n-1, j=n-1 SHALL enter DONE with done=1, so done rises n·n+1 = 101 edges after operation=10 is first sampled.
REQ-022 PROC: operation other than 10 on any edge SHALL abort to IDLE with done=0; results are then undefined.
REQ-023 DONE: SHALL hold while operation is 10 or 11.
REQ-024 DONE: operation 00 or 01 SHALL return to IDLE and clear done; a load on that same edge still writes.
REQ-025 y_re/y_im SHALL be combinational: result[addr] when operation=11 and addr<n, else 0.
REQ-026 The operation=11 decode SHALL not depend on done, although results are only meaningful when done=1.
REQ-027 done SHALL be registered and SHALL be 0 throughout loading.

Reset
REQ-028 reset low SHALL asynchronously force state=IDLE, done=0, k=j=0, accumulators=0, sample array=0 and result array=0.
REQ-029 With reset low, outputs y_re=y_im=0 and done=0 SHALL hold regardless of other inputs.
REQ-030 Operation SHALL resume on the first rising edge after reset is released.
REQ-031 reset asserted mid-PROC SHALL discard all partial results.

Verification
REQ-032 Ramp: load x=0..9 at addr 0..9, then operation=10.
- done rises 101 edges after 10 is first sampled.
- Read (re, im): addr0 = (45, 0), addr1 = (−5, 15), addr5 = (−5, 0), addr9 = (−5, −15).
REQ-033 Impulse: x[0]=100, others 0 -> every k reads y_re=100, y_im=0.
REQ-034 Constant: all x=7 -> k=0 reads (70, 0); every other k reads (0, 0).
REQ-035 Negative impulse: x[0]=−1000, others 0 -> every k reads y_re=−1000 (0xFFFFFC18), y_im=0.
REQ-036 Abort: operation drops to 00 at edge 50 of PROC -> done stays 0.
- A fresh operation=10 recomputes correctly, done rising 101 edges later.
REQ-037 Reset mid-run: reset low during PROC -> done=0 and outputs 0 immediately.
- Out-of-range check: operation=11 with addr=10 reads y_re=y_im=0.
